exp_sequencer: RTL and testbench

//  Consumes the data-cache exception summary from the read-operand stage plus external interrupts.

---
 rtl/exp_sequencer_pkg.sv | 27 ++
 rtl/exp_sequencer_if.sv | 46 ++++
 rtl/exp_sequencer_cause_sel.sv | 62 ++++++
 rtl/exp_sequencer.sv | 149 ++++++++++++++
 tb/tb_exp_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exp_sequencer_pkg.sv
// Shared definitions for the exception sequencer.
//   state_e         : 2-bit sequencer state encoding (IDLE, DRAIN, VECTOR, IN_ISR)
//   PF_VECTOR_DEF   : default page-fault vector
//   GP_VECTOR_DEF   : default protection (segment-limit / RW) vector
//   IDT_SHIFT       : log2 of the IDT entry size (8 bytes)
//   idt_entry_addr  : IDT base + vector * 8, wrapping at 32 bits
package exp_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2,
    ST_IN_ISR = 2'd3
  } state_e;

  localparam logic [7:0] PF_VECTOR_DEF = 8'd14;
  localparam logic [7:0] GP_VECTOR_DEF = 8'd13;
  localparam int unsigned IDT_SHIFT = 3;

  function automatic logic [31:0] idt_entry_addr(input logic [31:0] base,
                                                 input logic [7:0]  vec);
    logic [31:0] offset;
    offset = {24'b0, vec} << IDT_SHIFT;
    return base + offset;
  endfunction

endpackage

// File: rtl/exp_sequencer_if.sv
// Bus between the pipeline and the exception sequencer.
//   master : pipeline side (drives exception summary, interrupt, drain/IRET
//            status; receives flush/stall/redirect/handler state)
//   slave  : sequencer side
// Signal names follow the pipeline's existing naming.
interface exp_sequencer_if;
  logic        v_ro_valid;
  logic        dc_exp;
  logic        dc_prot_exp;
  logic        dc_page_fault;
  logic        dc_rd_exp;
  logic        dc_wr_exp;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_wr_addr;
  logic [31:0] ro_eip;
  logic        ext_int;
  logic [7:0]  ext_int_vec;
  logic        pipe_empty;
  logic        iret_done;

  logic        flush;
  logic        stall_ro;
  logic        isr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [7:0]  exp_vector;
  logic [31:0] saved_eip;
  logic [31:0] cr2;
  logic        double_fault;

  modport master (
    output v_ro_valid, dc_exp, dc_prot_exp, dc_page_fault, dc_rd_exp, dc_wr_exp,
           mem_rd_addr, mem_wr_addr, ro_eip, ext_int, ext_int_vec, pipe_empty,
           iret_done,
    input  flush, stall_ro, isr, redirect_valid, redirect_addr, exp_vector,
           saved_eip, cr2, double_fault
  );

  modport slave (
    input  v_ro_valid, dc_exp, dc_prot_exp, dc_page_fault, dc_rd_exp, dc_wr_exp,
           mem_rd_addr, mem_wr_addr, ro_eip, ext_int, ext_int_vec, pipe_empty,
           iret_done,
    output flush, stall_ro, isr, redirect_valid, redirect_addr, exp_vector,
           saved_eip, cr2, double_fault
  );
endinterface

// File: rtl/exp_sequencer_cause_sel.sv
// exp_cause_sel: combinational cause selection for the exception sequencer.
// Ports:
//   v_ro_valid_i, dc_*_i      : read-operand stage dcache exception summary
//   mem_rd_addr_i/mem_wr_addr_i: linear addresses of the faulting accesses
//   ext_int_i, ext_int_vec_i  : external interrupt request and its vector
//   take_o                    : something is to be taken this cycle
//   vector_o                  : vector for the winning cause
//   cr2_load_o, cr2_addr_o    : CR2 update request and value
module exp_cause_sel
  import exp_sequencer_pkg::*;
#(
  parameter logic [7:0] PF_VECTOR = PF_VECTOR_DEF,
  parameter logic [7:0] GP_VECTOR = GP_VECTOR_DEF
) (
  input  logic        v_ro_valid_i,
  input  logic        dc_exp_i,
  input  logic        dc_prot_exp_i,
  input  logic        dc_page_fault_i,
  input  logic        dc_rd_exp_i,
  input  logic        dc_wr_exp_i,
  input  logic [31:0] mem_rd_addr_i,
  input  logic [31:0] mem_wr_addr_i,
  input  logic        ext_int_i,
  input  logic [7:0]  ext_int_vec_i,
  output logic        take_o,
  output logic [7:0]  vector_o,
  output logic        cr2_load_o,
  output logic [31:0] cr2_addr_o
);

  logic       exc;
  logic [7:0] exc_vec;

  assign exc = v_ro_valid_i & dc_exp_i;

  // Page fault wins over a protection hit; an exception with no page-fault
  // classification is reported as a protection fault.
  always_comb begin
    exc_vec = GP_VECTOR;
    case ({dc_page_fault_i, dc_prot_exp_i})
      2'b10, 2'b11: exc_vec = PF_VECTOR;
      default:      exc_vec = GP_VECTOR;
    endcase
  end

  // Read side wins when both sides fault; with no side flagged the write
  // address is used.
  always_comb begin
    cr2_addr_o = mem_wr_addr_i;
    case ({dc_rd_exp_i, dc_wr_exp_i})
      2'b10, 2'b11: cr2_addr_o = mem_rd_addr_i;
      default:      cr2_addr_o = mem_wr_addr_i;
    endcase
  end

  // A data-cache exception always beats an external interrupt; the interrupt
  // is a level and is picked up again once the handler returns.
  assign take_o     = exc | ext_int_i;
  assign vector_o   = exc ? exc_vec : ext_int_vec_i;
  assign cr2_load_o = exc & dc_page_fault_i;

endmodule

// File: rtl/exp_sequencer.sv
// exp_sequencer: exception / interrupt entry sequencer.
// Captures cause, vector, faulting EIP and CR2 from the read-operand stage,
// flushes younger work, waits for the pipe to drain, redirects fetch to the
// IDT entry and holds isr until IRET retires.
// Ports:
//   clk  : core clock
//   rst  : asynchronous reset, active-high
//   bus  : exp_sequencer_if.slave
//          inputs  v_ro_valid, dc_exp, dc_prot_exp, dc_page_fault, dc_rd_exp,
//                  dc_wr_exp, mem_rd_addr, mem_wr_addr, ro_eip, ext_int,
//                  ext_int_vec, pipe_empty, iret_done
//          outputs flush, stall_ro, isr, redirect_valid, redirect_addr,
//                  exp_vector, saved_eip, cr2, double_fault
// All outputs are registered except redirect_addr, which is derived
// combinationally from the captured vector.
module exp_sequencer
  import exp_sequencer_pkg::*;
#(
  parameter logic [31:0] IDT_BASE  = 32'h0000_0000,
  parameter logic [7:0]  PF_VECTOR = PF_VECTOR_DEF,
  parameter logic [7:0]  GP_VECTOR = GP_VECTOR_DEF
) (
  input logic           clk,
  input logic           rst,
  exp_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic        stall_q, stall_d;
  logic        isr_q, isr_d;
  logic        redir_q, redir_d;
  logic [7:0]  vec_q, vec_d;
  logic [31:0] eip_q, eip_d;
  logic [31:0] cr2_q, cr2_d;
  logic        df_q, df_d;

  logic        sel_take;
  logic [7:0]  sel_vec;
  logic        sel_cr2_load;
  logic [31:0] sel_cr2_addr;

  exp_cause_sel #(
    .PF_VECTOR (PF_VECTOR),
    .GP_VECTOR (GP_VECTOR)
  ) u_cause_sel (
    .v_ro_valid_i    (bus.v_ro_valid),
    .dc_exp_i        (bus.dc_exp),
    .dc_prot_exp_i   (bus.dc_prot_exp),
    .dc_page_fault_i (bus.dc_page_fault),
    .dc_rd_exp_i     (bus.dc_rd_exp),
    .dc_wr_exp_i     (bus.dc_wr_exp),
    .mem_rd_addr_i   (bus.mem_rd_addr),
    .mem_wr_addr_i   (bus.mem_wr_addr),
    .ext_int_i       (bus.ext_int),
    .ext_int_vec_i   (bus.ext_int_vec),
    .take_o          (sel_take),
    .vector_o        (sel_vec),
    .cr2_load_o      (sel_cr2_load),
    .cr2_addr_o      (sel_cr2_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      isr_q   <= 1'b0;
      redir_q <= 1'b0;
      vec_q   <= 8'h00;
      eip_q   <= 32'h0;
      cr2_q   <= 32'h0;
      df_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      isr_q   <= isr_d;
      redir_q <= redir_d;
      vec_q   <= vec_d;
      eip_q   <= eip_d;
      cr2_q   <= cr2_d;
      df_q    <= df_d;
    end
  end

  // Outputs are the next-state values registered, so every control output
  // appears in the cycle of the state it belongs to.
  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    stall_d = 1'b0;
    isr_d   = 1'b0;
    redir_d = 1'b0;
    vec_d   = vec_q;
    eip_d   = eip_q;
    cr2_d   = cr2_q;
    df_d    = df_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_take) begin
          state_d = ST_DRAIN;
          flush_d = 1'b1;
          stall_d = 1'b1;
          vec_d   = sel_vec;
          // The faulting / interrupted instruction restarts after IRET.
          eip_d   = bus.ro_eip;
          if (sel_cr2_load) cr2_d = sel_cr2_addr;
        end
      end
      ST_DRAIN: begin
        stall_d = 1'b1;
        if (bus.pipe_empty) begin
          state_d = ST_VECTOR;
          redir_d = 1'b1;
          isr_d   = 1'b1;
        end
      end
      ST_VECTOR: begin
        state_d = ST_IN_ISR;
        isr_d   = 1'b1;
      end
      ST_IN_ISR: begin
        isr_d = 1'b1;
        if (bus.iret_done) begin
          // A simultaneous exception is not a double fault: it is seen again
          // from IDLE on the following cycle.
          state_d = ST_IDLE;
          isr_d   = 1'b0;
        end else if (bus.v_ro_valid && bus.dc_exp) begin
          df_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.flush          = flush_q;
  assign bus.stall_ro       = stall_q;
  assign bus.isr            = isr_q;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_addr  = idt_entry_addr(IDT_BASE, vec_q);
  assign bus.exp_vector     = vec_q;
  assign bus.saved_eip      = eip_q;
  assign bus.cr2            = cr2_q;
  assign bus.double_fault   = df_q;

endmodule

// File: tb/tb_exp_sequencer.sv
module tb_exp_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  vec;
    logic [31:0] eip;
    logic [31:0] cr2;
  } redir_t;

  redir_t sb[$];

  exp_sequencer_if bus ();
  exp_sequencer_if bus2 ();

  exp_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_sequencer #(.IDT_BASE(32'hFFFF_FFF8)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every redirect of the main DUT must match the oldest entry.
  always @(negedge clk) begin
    if (bus.redirect_valid === 1'b1) begin
      redir_t e;
      redir_t got;
      checks++;
      got = {bus.redirect_addr, bus.exp_vector, bus.saved_eip, bus.cr2};
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_redirect got addr=%h vec=%h", bus.redirect_addr, bus.exp_vector);
      end else begin
        e = sb.pop_front();
        if (got !== e)
          begin
            failures++;
            $display("FAIL sb_redirect got addr=%h vec=%h eip=%h cr2=%h exp addr=%h vec=%h eip=%h cr2=%h",
                     got.addr, got.vec, got.eip, got.cr2, e.addr, e.vec, e.eip, e.cr2);
          end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.v_ro_valid = 0; bus.dc_exp = 0; bus.dc_prot_exp = 0; bus.dc_page_fault = 0;
    bus.dc_rd_exp = 0; bus.dc_wr_exp = 0; bus.mem_rd_addr = 0; bus.mem_wr_addr = 0;
    bus.ro_eip = 0; bus.ext_int = 0; bus.ext_int_vec = 0; bus.pipe_empty = 0;
    bus.iret_done = 0;
  endtask

  task automatic iret_pulse();
    bus.iret_done = 1;
    step();
    bus.iret_done = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    checks++;
    if ({bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid, bus.double_fault} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid, bus.double_fault});
    end
    checks++;
    if ({bus.exp_vector, bus.saved_eip, bus.cr2, bus.redirect_addr} !== 104'b0) begin
      failures++;
      $display("FAIL reset_data got vec=%h eip=%h cr2=%h addr=%h exp 0",
               bus.exp_vector, bus.saved_eip, bus.cr2, bus.redirect_addr);
    end
    rst = 0;
    step();
  endtask

  task automatic test_read_page_fault();
    bus.pipe_empty = 1; bus.v_ro_valid = 1; bus.dc_exp = 1; bus.dc_page_fault = 1;
    bus.dc_rd_exp = 1; bus.mem_rd_addr = 32'h0040_1234; bus.mem_wr_addr = 32'h0BAD_0000;
    bus.ro_eip = 32'h100;
    sb.push_back('{32'h70, 8'd14, 32'h100, 32'h0040_1234});
    step();
    clear_inputs(); bus.pipe_empty = 1;
    checks++;
    if ({bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL pf_capture_ctrl got=%b exp=1100", {bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid});
    end
    checks++;
    if ({bus.exp_vector, bus.saved_eip, bus.cr2} !== {8'd14, 32'h100, 32'h0040_1234}) begin
      failures++;
      $display("FAIL pf_capture_regs got vec=%h eip=%h cr2=%h exp 0e/100/00401234",
               bus.exp_vector, bus.saved_eip, bus.cr2);
    end
    step();
    checks++;
    if ({bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid, bus.redirect_addr} !== {4'b0111, 32'h70}) begin
      failures++;
      $display("FAIL pf_vector got ctrl=%b addr=%h exp 0111/00000070",
               {bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid}, bus.redirect_addr);
    end
    step();
    checks++;
    if ({bus.stall_ro, bus.isr, bus.redirect_valid} !== 3'b010) begin
      failures++;
      $display("FAIL pf_in_isr got=%b exp=010", {bus.stall_ro, bus.isr, bus.redirect_valid});
    end
    iret_pulse();
    checks++;
    if (bus.isr !== 1'b0) begin
      failures++;
      $display("FAIL pf_iret isr got=%b exp=0", bus.isr);
    end
  endtask

  task automatic test_write_limit();
    bus.pipe_empty = 0; bus.v_ro_valid = 1; bus.dc_exp = 1; bus.dc_prot_exp = 1;
    bus.dc_wr_exp = 1; bus.mem_wr_addr = 32'hDEAD_0000; bus.ro_eip = 32'h200;
    sb.push_back('{32'h68, 8'd13, 32'h200, 32'h0040_1234});
    step();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.stall_ro, bus.redirect_valid, bus.isr} !== 3'b100) begin
        failures++;
        $display("FAIL gp_drain_%0d got=%b exp=100", i, {bus.stall_ro, bus.redirect_valid, bus.isr});
      end
      step();
    end
    bus.pipe_empty = 1;
    step();
    checks++;
    if ({bus.stall_ro, bus.redirect_valid, bus.redirect_addr, bus.cr2} !== {2'b11, 32'h68, 32'h0040_1234}) begin
      failures++;
      $display("FAIL gp_vector got st=%b rv=%b addr=%h cr2=%h exp 1/1/00000068/00401234",
               bus.stall_ro, bus.redirect_valid, bus.redirect_addr, bus.cr2);
    end
    step();
    checks++;
    if (bus.stall_ro !== 1'b0) begin
      failures++;
      $display("FAIL gp_stall_release got=%b exp=0", bus.stall_ro);
    end
    iret_pulse();
  endtask

  task automatic test_ext_int_priority();
    bus.pipe_empty = 1; bus.ext_int = 1; bus.ext_int_vec = 8'h20;
    bus.v_ro_valid = 1; bus.dc_exp = 1; bus.dc_page_fault = 1; bus.dc_wr_exp = 1;
    bus.mem_wr_addr = 32'h0000_5000; bus.mem_rd_addr = 32'h0000_7777; bus.ro_eip = 32'h180;
    sb.push_back('{32'h70, 8'd14, 32'h180, 32'h0000_5000});
    step();
    bus.v_ro_valid = 0; bus.dc_exp = 0; bus.dc_page_fault = 0; bus.dc_wr_exp = 0;
    checks++;
    if (bus.exp_vector !== 8'd14) begin
      failures++;
      $display("FAIL prio_vector got=%h exp=0e", bus.exp_vector);
    end
    step(); step();
    step(); step();
    checks++;
    if ({bus.isr, bus.flush, bus.exp_vector} !== {2'b10, 8'd14}) begin
      failures++;
      $display("FAIL prio_ext_ignored got isr=%b flush=%b vec=%h exp 1/0/0e",
               bus.isr, bus.flush, bus.exp_vector);
    end
    bus.ro_eip = 32'h300;
    sb.push_back('{32'h100, 8'h20, 32'h300, 32'h0000_5000});
    iret_pulse();
    checks++;
    if (bus.isr !== 1'b0) begin
      failures++;
      $display("FAIL prio_iret isr got=%b exp=0", bus.isr);
    end
    step();
    bus.ext_int = 0;
    checks++;
    if ({bus.flush, bus.exp_vector, bus.saved_eip} !== {1'b1, 8'h20, 32'h300}) begin
      failures++;
      $display("FAIL prio_ext_taken got flush=%b vec=%h eip=%h exp 1/20/00000300",
               bus.flush, bus.exp_vector, bus.saved_eip);
    end
    step(); step();
    iret_pulse();
  endtask

  task automatic test_double_fault();
    bus.pipe_empty = 1; bus.v_ro_valid = 1; bus.dc_exp = 1; bus.dc_prot_exp = 1;
    bus.dc_rd_exp = 1; bus.mem_rd_addr = 32'h1111_0000; bus.ro_eip = 32'h400;
    sb.push_back('{32'h68, 8'd13, 32'h400, 32'h0000_5000});
    step();
    clear_inputs(); bus.pipe_empty = 1;
    step(); step();
    bus.v_ro_valid = 1; bus.dc_exp = 1; bus.dc_page_fault = 1; bus.dc_rd_exp = 1;
    bus.mem_rd_addr = 32'h0000_0BAD; bus.ro_eip = 32'h999;
    step();
    clear_inputs(); bus.pipe_empty = 1;
    checks++;
    if ({bus.double_fault, bus.isr, bus.flush} !== 3'b110) begin
      failures++;
      $display("FAIL df_flag got df=%b isr=%b flush=%b exp 1/1/0", bus.double_fault, bus.isr, bus.flush);
    end
    checks++;
    if ({bus.exp_vector, bus.saved_eip, bus.cr2} !== {8'd13, 32'h400, 32'h0000_5000}) begin
      failures++;
      $display("FAIL df_regs got vec=%h eip=%h cr2=%h exp 0d/00000400/00005000",
               bus.exp_vector, bus.saved_eip, bus.cr2);
    end
    iret_pulse();
    checks++;
    if ({bus.isr, bus.double_fault} !== 2'b01) begin
      failures++;
      $display("FAIL df_iret got isr=%b df=%b exp 0/1", bus.isr, bus.double_fault);
    end
  endtask

  task automatic test_reset_mid_sequence();
    // Reset while draining: no redirect may follow.
    bus.pipe_empty = 0; bus.v_ro_valid = 1; bus.dc_exp = 1; bus.dc_page_fault = 1;
    bus.dc_rd_exp = 1; bus.mem_rd_addr = 32'h2222_0000; bus.ro_eip = 32'h500;
    step();
    clear_inputs();
    rst = 1;
    #1;
    checks++;
    if ({bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid, bus.double_fault,
         bus.exp_vector, bus.saved_eip, bus.cr2} !== 77'b0) begin
      failures++;
      $display("FAIL rst_drain got ctrl=%b vec=%h eip=%h cr2=%h exp 0",
               {bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid, bus.double_fault},
               bus.exp_vector, bus.saved_eip, bus.cr2);
    end
    step();
    rst = 0;
    bus.pipe_empty = 1;
    step(); step(); step();
    // Reset while in the handler.
    bus.v_ro_valid = 1; bus.dc_exp = 1; bus.dc_prot_exp = 1; bus.dc_wr_exp = 1;
    bus.ro_eip = 32'h600;
    sb.push_back('{32'h68, 8'd13, 32'h600, 32'h0});
    step();
    clear_inputs(); bus.pipe_empty = 1;
    step(); step();
    rst = 1;
    #1;
    checks++;
    if ({bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid, bus.double_fault,
         bus.exp_vector, bus.saved_eip, bus.cr2} !== 77'b0) begin
      failures++;
      $display("FAIL rst_isr got ctrl=%b vec=%h eip=%h cr2=%h exp 0",
               {bus.flush, bus.stall_ro, bus.isr, bus.redirect_valid, bus.double_fault},
               bus.exp_vector, bus.saved_eip, bus.cr2);
    end
    step();
    rst = 0;
    step(); step();
  endtask

  task automatic test_idt_wrap();
    bus2.pipe_empty = 1; bus2.ext_int = 1; bus2.ext_int_vec = 8'd1;
    step();
    bus2.ext_int = 0;
    step();
    checks++;
    if ({bus2.redirect_valid, bus2.redirect_addr} !== {1'b1, 32'h0000_0000}) begin
      failures++;
      $display("FAIL idt_wrap got rv=%b addr=%h exp 1/00000000", bus2.redirect_valid, bus2.redirect_addr);
    end
    step();
    bus2.iret_done = 1;
    step();
    bus2.iret_done = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    clear_inputs();
    bus2.v_ro_valid = 0; bus2.dc_exp = 0; bus2.dc_prot_exp = 0; bus2.dc_page_fault = 0;
    bus2.dc_rd_exp = 0; bus2.dc_wr_exp = 0; bus2.mem_rd_addr = 0; bus2.mem_wr_addr = 0;
    bus2.ro_eip = 0; bus2.ext_int = 0; bus2.ext_int_vec = 0; bus2.pipe_empty = 0;
    bus2.iret_done = 0;

    test_reset();
    test_read_page_fault();
    test_write_limit();
    test_ext_int_priority();
    test_double_fault();
    test_reset_mid_sequence();
    test_idt_wrap();

    step(); step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_pending got=%0d redirects outstanding exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
